// File: rtl/tick_sequencer.sv
// Programmable tick generator: divides the clock by (div+1), issues one-cycle
// ticks and a toggled divided clock, optionally stopping after a burst of ticks.
module tick_sequencer #(
  parameter int CNT_W       = 7,
  parameter int BURST_W     = 8,
  parameter int DEFAULT_DIV = 49
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               tick,
  output logic               scaledclk,
  output logic [BURST_W-1:0] tick_count,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   div_reg, div_n;
  logic [BURST_W-1:0] burst_reg, burst_n;
  logic [CNT_W-1:0]   counter, counter_n;
  logic [BURST_W-1:0] tick_count_n;
  logic               scaledclk_n;
  logic [BURST_W-1:0] tick_count_inc;

  assign busy           = (state == RUN);
  assign done           = (state == DONE);
  assign cfg_ready      = (state == IDLE) && !reset;
  // Stop and reset both veto the terminal-count decode in the same cycle.
  assign tick           = (state == RUN) && (counter == div_reg) && !stop && !reset;
  assign tick_count_inc = tick_count + BURST_W'(1);

  always_comb begin
    state_n      = state;
    div_n        = div_reg;
    burst_n      = burst_reg;
    counter_n    = counter;
    tick_count_n = tick_count;
    scaledclk_n  = scaledclk;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          div_n   = cfg_div;
          burst_n = cfg_burst;
        end
        if (start) begin
          state_n      = RUN;
          counter_n    = '0;
          tick_count_n = '0;
          scaledclk_n  = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_n     = IDLE;
          counter_n   = '0;
          scaledclk_n = 1'b0;
        end else if (counter == div_reg) begin
          counter_n    = '0;
          tick_count_n = tick_count_inc;
          if ((burst_reg != '0) && (tick_count_inc == burst_reg)) begin
            state_n     = DONE;
            scaledclk_n = 1'b0;
          end else begin
            scaledclk_n = ~scaledclk;
          end
        end else begin
          counter_n = counter + CNT_W'(1);
        end
      end
      DONE: begin
        state_n     = IDLE;
        counter_n   = '0;
        scaledclk_n = 1'b0;
      end
      default: begin
        state_n     = IDLE;
        counter_n   = '0;
        scaledclk_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      div_reg    <= CNT_W'(DEFAULT_DIV);
      burst_reg  <= '0;
      counter    <= '0;
      tick_count <= '0;
      scaledclk  <= 1'b0;
    end else begin
      state      <= state_n;
      div_reg    <= div_n;
      burst_reg  <= burst_n;
      counter    <= counter_n;
      tick_count <= tick_count_n;
      scaledclk  <= scaledclk_n;
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Scoreboard bench for tick_sequencer: directed scenarios plus random traffic,
// checked against a run-time arithmetic model of the tick schedule.
module tb_tick_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [6:0] cfg_div = '0;
  logic [7:0] cfg_burst = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy, tick, scaledclk, done;
  logic [7:0] tick_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       busy;
    logic       tick;
    logic       sclk;
    logic       done;
    logic       rdy;
    logic [7:0] tc;
  } exp_t;

  exp_t q[$];

  // model: where we are in a run, measured in RUN cycles and ticks issued
  bit in_run  = 0;
  bit in_done = 0;
  int m_div   = 49;
  int m_burst = 0;
  int run_cyc = 0;
  int ticks   = 0;

  tick_sequencer dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .busy(busy), .tick(tick), .scaledclk(scaledclk), .tick_count(tick_count),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("tick", 32'(tick), 32'(e.tick));
      chk("scaledclk", 32'(scaledclk), 32'(e.sclk));
      chk("done", 32'(done), 32'(e.done));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      chk("tick_count", 32'(tick_count), 32'(e.tc));
    end
  end

  // One clock cycle: apply inputs, predict this cycle's outputs, advance model.
  task automatic cyc(input bit r, input bit st, input bit sp, input bit cv,
                     input int d, input int b);
    exp_t e;
    bit   idle, tk;
    @(posedge clock);
    #1;
    reset = r; start = st; stop = sp; cfg_valid = cv;
    cfg_div = 7'(d); cfg_burst = 8'(b);
    idle = !in_run && !in_done;
    tk   = in_run && !r && !sp && (((run_cyc + 1) % (m_div + 1)) == 0);
    e.busy = in_run;
    e.tick = tk;
    e.sclk = in_run ? ticks[0] : 1'b0;
    e.done = in_done;
    e.rdy  = idle && !r;
    e.tc   = 8'(ticks % 256);
    q.push_back(e);
    if (r) begin
      in_run = 0; in_done = 0; m_div = 49; m_burst = 0; ticks = 0; run_cyc = 0;
    end else if (idle) begin
      if (cv) begin
        m_div = d; m_burst = b;
      end
      if (st) begin
        in_run = 1; run_cyc = 0; ticks = 0;
      end
    end else if (in_run) begin
      if (sp) begin
        in_run = 0;
      end else begin
        run_cyc++;
        if (tk) begin
          ticks++;
          if (m_burst != 0 && (ticks % 256) == m_burst) begin
            in_run = 0; in_done = 1;
          end
        end
      end
    end else begin
      in_done = 0;
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clock);
    #1;
    // reset state
    cyc(1, 1, 1, 1, 3, 3);
    cyc(1, 0, 0, 0, 0, 0);
    idle_n(2);

    // default divider run, covers two scaledclk periods
    cyc(0, 1, 0, 0, 0, 0);
    idle_n(210);
    cyc(0, 0, 1, 0, 0, 0);
    idle_n(3);

    // burst of 5 with config offered alongside start
    cyc(0, 1, 0, 1, 3, 5);
    idle_n(25);

    // stop colliding with the third tick of a continuous run
    cyc(0, 1, 0, 1, 9, 0);
    idle_n(29);
    cyc(0, 0, 1, 0, 0, 0);
    idle_n(3);

    // div 0, burst 1: single tick then done
    cyc(0, 1, 0, 1, 0, 1);
    idle_n(3);
    // continuous div 1; config offered mid-run must be ignored
    cyc(0, 1, 0, 1, 1, 0);
    idle_n(4);
    cyc(0, 0, 0, 1, 5, 2);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // div 0 continuous: tick every cycle
    cyc(0, 1, 0, 1, 0, 0);
    idle_n(6);
    cyc(0, 0, 1, 0, 0, 0);
    idle_n(2);

    // reset mid-run restores the default divider
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 4, 0);
    idle_n(20);
    cyc(1, 1, 1, 1, 2, 2);
    idle_n(2);
    cyc(0, 1, 0, 0, 0, 0);
    idle_n(55);
    cyc(0, 0, 1, 0, 0, 0);

    // random traffic with small dividers and bursts
    for (int i = 0; i < 4000; i++) begin
      bit r, st, sp, cv;
      r  = ($urandom_range(299, 0) == 0);
      st = ($urandom_range(7, 0) == 0);
      sp = ($urandom_range(39, 0) == 0);
      cv = ($urandom_range(5, 0) == 0);
      cyc(r, st, sp, cv, int'($urandom_range(7, 0)), int'($urandom_range(6, 0)));
    end

    idle_n(1);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
